// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a valid/ready handshake
// on both sides, a synchronous flush that inserts a bubble word, an optional
// 2-entry skid buffer, and saturating stall/flush counters for debug.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 SKID       = 1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              keep,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic              accept;
  logic              do_release;
  logic              stall_event;
  logic              flush_event;

  // The main register is what downstream sees; an empty stage shows the bubble.
  assign out_valid  = main_valid;
  assign out_data   = main_valid ? main_data : BUBBLE_VAL;
  assign accept     = in_valid & in_ready;
  assign do_release = main_valid & out_ready & ~keep;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data;
      logic              skid_valid_q;

      assign skid_valid = skid_valid_q;
      assign in_ready   = ~skid_valid_q & ~keep & ~flush;

      // Main/skid pair: overflow parks in the skid entry, which refills main first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid   <= 1'b0;
          main_data    <= BUBBLE_VAL;
          skid_valid_q <= 1'b0;
          skid_data    <= BUBBLE_VAL;
        end else if (flush) begin
          main_valid   <= 1'b0;
          main_data    <= BUBBLE_VAL;
          skid_valid_q <= 1'b0;
        end else if (!main_valid) begin
          if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end
        end else if (do_release) begin
          if (skid_valid_q) begin
            main_data    <= skid_data;
            skid_valid_q <= 1'b0;
          end else if (accept) begin
            main_data <= in_data;
          end else begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
          end
        end else if (accept) begin
          skid_valid_q <= 1'b1;
          skid_data    <= in_data;
        end
      end
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign in_ready   = (~main_valid | out_ready) & ~keep & ~flush;

      // Single register: refill on accept, drain to the bubble on a bare release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= BUBBLE_VAL;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= BUBBLE_VAL;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (do_release) begin
          main_valid <= 1'b0;
          main_data  <= BUBBLE_VAL;
        end
      end
    end
  endgenerate

  assign stall_event = ~flush & (keep | (main_valid & ~out_ready));
  assign flush_event = flush & (main_valid | skid_valid);

  // Saturating performance counters; flush cycles never count as stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_event && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg. Instance A (SKID=1)
// is checked by a release monitor against a queue of expected bundles;
// instance C shares A's inputs with a 4-bit counter; instance B is SKID=0.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_flush, a_keep, a_in_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  logic        b_flush, b_keep, b_in_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Free-running stage clock.
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h0), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .keep(a_keep),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h0), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .keep(a_keep),
    .in_valid(a_in_valid), .in_ready(c_in_ready), .in_data(a_in_data),
    .out_valid(c_out_valid), .out_ready(a_out_ready), .out_data(c_out_data),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h0), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .keep(b_keep),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus on instance A; accepted bundles go to the scoreboard.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy,
                               input logic kp, input logic fl, input logic exp_rdy);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = ordy;
    a_keep      = kp;
    a_flush     = fl;
    @(negedge clk);
    checkOutput("a_in_ready", {31'b0, a_in_ready}, {31'b0, exp_rdy});
    if (v && exp_rdy) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  // Release monitor: every bundle handed downstream must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && a_out_ready && !a_keep) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL release_unexpected: got %h expected none", a_out_data);
        end else begin
          checkOutput("release_data", a_out_data, exp_q.pop_front());
        end
      end else if (!a_out_valid) begin
        checkOutput("bubble_data", a_out_data, 32'h0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_keep = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_keep = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    #12;
    checkOutput("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
    checkOutput("rst_out_data", a_out_data, 32'h0);
    checkOutput("rst_in_ready", {31'b0, a_in_ready}, 32'h1);
    checkOutput("rst_stall_cnt", {16'b0, a_stall_cnt}, 32'h0);
    checkOutput("rst_flush_cnt", {16'b0, a_flush_cnt}, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    applyStimulus(1, 32'h100, 1, 0, 0, 1);
    applyStimulus(1, 32'h104, 1, 0, 0, 1);
    applyStimulus(1, 32'h108, 1, 0, 0, 1);
    applyStimulus(0, 32'h0,   1, 0, 0, 1);
    checkOutput("stream_stall_cnt", {16'b0, a_stall_cnt}, 32'd0);

    // Backpressure fills main then skid
    applyStimulus(1, 32'hA, 0, 0, 0, 1);
    applyStimulus(1, 32'hB, 0, 0, 0, 1);
    applyStimulus(1, 32'hC, 0, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);
    checkOutput("bp_stall_cnt", {16'b0, a_stall_cnt}, 32'd3);
    applyStimulus(0, 32'h0, 1, 0, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0, 1);
    checkOutput("bp_drained_valid", {31'b0, a_out_valid}, 32'h0);

    // Flush with both entries live, then flush an empty stage
    applyStimulus(1, 32'h8C220004, 0, 0, 0, 1);
    applyStimulus(1, 32'h11111111, 0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 1, 0);
    checkOutput("flush_out_valid", {31'b0, a_out_valid}, 32'h0);
    checkOutput("flush_out_data", a_out_data, 32'h0);
    checkOutput("flush_cnt_live", {16'b0, a_flush_cnt}, 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 1, 0);
    checkOutput("flush_cnt_empty", {16'b0, a_flush_cnt}, 32'd1);
    checkOutput("flush_stall_cnt", {16'b0, a_stall_cnt}, 32'd4);

    // Keep holds the stage even with downstream ready
    applyStimulus(1, 32'h1234, 1, 0, 0, 1);
    repeat (3) applyStimulus(0, 32'h0, 1, 1, 0, 0);
    checkOutput("keep_out_valid", {31'b0, a_out_valid}, 32'h1);
    checkOutput("keep_out_data", a_out_data, 32'h1234);
    checkOutput("keep_stall_cnt", {16'b0, a_stall_cnt}, 32'd7);
    applyStimulus(0, 32'h0, 1, 1, 1, 0);
    checkOutput("keepflush_valid", {31'b0, a_out_valid}, 32'h0);
    checkOutput("keepflush_stall", {16'b0, a_stall_cnt}, 32'd7);
    checkOutput("keepflush_fcnt", {16'b0, a_flush_cnt}, 32'd2);

    // Long stall saturates the 4-bit counter
    repeat (20) applyStimulus(0, 32'h0, 0, 1, 0, 0);
    checkOutput("sat_a_stall", {16'b0, a_stall_cnt}, 32'd27);
    checkOutput("sat_c_stall", {28'b0, c_stall_cnt}, 32'd15);
    checkOutput("sat_c_flush", {28'b0, c_flush_cnt}, 32'd2);

    // Mixed ready pattern exercising skid refill
    applyStimulus(1, 32'hD0, 0, 0, 0, 1);
    applyStimulus(1, 32'hD1, 1, 0, 0, 1);
    applyStimulus(1, 32'hD2, 1, 0, 0, 1);
    applyStimulus(1, 32'hD3, 0, 0, 0, 1);
    applyStimulus(1, 32'hD4, 1, 0, 0, 0);
    applyStimulus(1, 32'hD4, 1, 0, 0, 1);
    applyStimulus(0, 32'h0,  1, 0, 0, 1);
    checkOutput("mix_stall_cnt", {16'b0, a_stall_cnt}, 32'd28);

    // Asynchronous reset in the middle of a cycle
    applyStimulus(1, 32'hAB, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'b0, a_out_valid}, 32'h0);
    checkOutput("arst_out_data", a_out_data, 32'h0);
    checkOutput("arst_stall_cnt", {16'b0, a_stall_cnt}, 32'h0);
    checkOutput("arst_flush_cnt", {16'b0, a_flush_cnt}, 32'h0);
    checkOutput("arst_c_stall", {28'b0, c_stall_cnt}, 32'h0);
    exp_q.delete();
    a_in_valid = 0; a_out_ready = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 32'h77, 1, 0, 0, 1);
    applyStimulus(0, 32'h0,  1, 0, 0, 1);

    // SKID=0 instance: combinational ready path
    b_in_valid = 1; b_in_data = 32'h33; b_out_ready = 0;
    @(negedge clk);
    checkOutput("b_rdy_empty", {31'b0, b_in_ready}, 32'h1);
    @(posedge clk); #1;
    b_in_data = 32'h44;
    @(negedge clk);
    checkOutput("b_rdy_blocked", {31'b0, b_in_ready}, 32'h0);
    @(posedge clk); #1;
    b_out_ready = 1; b_in_data = 32'h55;
    #1;
    checkOutput("b_rdy_sameclk", {31'b0, b_in_ready}, 32'h1);
    @(negedge clk);
    checkOutput("b_out_old", b_out_data, 32'h33);
    @(posedge clk); #1;
    checkOutput("b_out_new", b_out_data, 32'h55);
    checkOutput("b_out_valid", {31'b0, b_out_valid}, 32'h1);
    b_in_valid = 0;
    @(posedge clk); #1;
    checkOutput("b_drain_valid", {31'b0, b_out_valid}, 32'h0);
    checkOutput("b_drain_data", b_out_data, 32'h0);
    checkOutput("b_stall_cnt", {16'b0, b_stall_cnt}, 32'd1);
    checkOutput("b_flush_cnt", {16'b0, b_flush_cnt}, 32'd0);
    b_keep = 1; b_in_valid = 1;
    #1;
    checkOutput("b_rdy_keep", {31'b0, b_in_ready}, 32'h0);
    b_keep = 0; b_in_valid = 0;

    // Final state
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    checkOutput("c_end_valid", {31'b0, c_out_valid}, 32'h0);
    checkOutput("c_end_data", c_out_data, 32'h0);
    checkOutput("c_end_ready", {31'b0, c_in_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
